// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory-stage load/store unit. Turns each load or store in the M stage into
//   one valid/ready transaction on the data-memory bus. It forms byte lanes and
//   replicates store data, aligns and extends load data, stalls the pipeline
//   while a transaction is outstanding, and flags misaligned accesses and bus
//   timeouts.
//
// Parameters
//   TIMEOUT_CYCLES    cycles allowed in REQ or WAIT before a bus error (1..255)
//
// Ports
//   CLK, RST                       clock, synchronous active-high reset
//   MEM_R_En_M / MEM_W_En_M        M-stage load / store (store wins if both set)
//   MEM_Control_M [2:0]            RV32I funct3 (access size and signedness)
//   ALU_Out_M [31:0]               effective byte address
//   REG_R_Data2_M [31:0]           right-justified store data
//   DMEM_Req_*                     request channel (valid/ready, addr, lanes, data)
//   DMEM_Rsp_Valid / DMEM_Rsp_Data read response
//   MEM_Stall                      freeze upstream stages, bubble into MEM/WB
//   MEM_Load_Data_M [31:0]         aligned, extended load result
//   MEM_Misaligned                 misaligned access, retired without bus traffic
//   MEM_Bus_Err                    transaction abandoned on timeout (DONE cycle)

module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MEM_R_En_M,
    input  logic        MEM_W_En_M,
    input  logic [2:0]  MEM_Control_M,
    input  logic [31:0] ALU_Out_M,
    input  logic [31:0] REG_R_Data2_M,
    output logic        DMEM_Req_Valid,
    input  logic        DMEM_Req_Ready,
    output logic [31:0] DMEM_Req_Addr,
    output logic        DMEM_Req_W_En,
    output logic [3:0]  DMEM_Req_Byte_En,
    output logic [31:0] DMEM_Req_W_Data,
    input  logic        DMEM_Rsp_Valid,
    input  logic [31:0] DMEM_Rsp_Data,
    output logic        MEM_Stall,
    output logic [31:0] MEM_Load_Data_M,
    output logic        MEM_Misaligned,
    output logic        MEM_Bus_Err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        w_en_q, w_en_d;
    logic [3:0]  byte_en_q, byte_en_d;
    logic [31:0] w_data_q, w_data_d;
    logic [1:0]  offset_q, offset_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] load_data_q, load_data_d;
    logic        bus_err_q, bus_err_d;

    // M-stage decode, only meaningful while IDLE.
    logic        access;
    logic        misaligned;
    logic [3:0]  store_be;
    logic [31:0] store_wd;
    logic [31:0] rsp_shifted;
    logic [31:0] load_aligned;
    logic [7:0]  cnt_inc;
    logic        timeout_hit;

    assign access      = MEM_R_En_M | MEM_W_En_M;
    assign misaligned  = ((MEM_Control_M[1:0] == 2'b01) & ALU_Out_M[0]) |
                         ((MEM_Control_M == 3'b010) & (ALU_Out_M[1:0] != 2'b00));
    assign cnt_inc     = cnt_q + 8'd1;
    assign timeout_hit = (cnt_inc == TIMEOUT_LIMIT);

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        store_be = 4'b0000;
        store_wd = REG_R_Data2_M;
        case (MEM_Control_M)
            3'b000: begin
                store_be = 4'b0001 << ALU_Out_M[1:0];
                store_wd = {4{REG_R_Data2_M[7:0]}};
            end
            3'b001: begin
                store_be = 4'b0011 << {ALU_Out_M[1], 1'b0};
                store_wd = {2{REG_R_Data2_M[15:0]}};
            end
            3'b010: store_be = 4'b1111;
            default: ;
        endcase
    end

    // Response alignment uses the offset/funct3 captured at request time,
    // since the M-stage inputs are frozen but not guaranteed meaningful later.
    assign rsp_shifted = DMEM_Rsp_Data >> {offset_q, 3'b000};

    always_comb begin
        load_aligned = DMEM_Rsp_Data;
        case (funct3_q)
            3'b000: load_aligned = {{24{rsp_shifted[7]}},  rsp_shifted[7:0]};
            3'b001: load_aligned = {{16{rsp_shifted[15]}}, rsp_shifted[15:0]};
            3'b100: load_aligned = {24'd0, rsp_shifted[7:0]};
            3'b101: load_aligned = {16'd0, rsp_shifted[15:0]};
            default: ;
        endcase
    end

    // State register and datapath registers.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (RST) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            w_en_q      <= 1'b0;
            byte_en_q   <= '0;
            w_data_q    <= '0;
            offset_q    <= '0;
            funct3_q    <= '0;
            cnt_q       <= '0;
            load_data_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            w_en_q      <= w_en_d;
            byte_en_q   <= byte_en_d;
            w_data_q    <= w_data_d;
            offset_q    <= offset_d;
            funct3_q    <= funct3_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        w_en_d      = w_en_q;
        byte_en_d   = byte_en_q;
        w_data_d    = w_data_q;
        offset_d    = offset_q;
        funct3_d    = funct3_q;
        cnt_d       = cnt_q;
        load_data_d = load_data_q;
        bus_err_d   = bus_err_q;
        case (state_q)
            IDLE: begin
                if (access && !misaligned) begin
                    addr_d    = {ALU_Out_M[31:2], 2'b00};
                    w_en_d    = MEM_W_En_M;
                    byte_en_d = MEM_W_En_M ? store_be : 4'b1111;
                    w_data_d  = MEM_W_En_M ? store_wd : 32'd0;
                    offset_d  = ALU_Out_M[1:0];
                    funct3_d  = MEM_Control_M;
                    cnt_d     = '0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (DMEM_Req_Ready) begin
                    cnt_d   = '0;
                    state_d = w_en_q ? DONE : WAIT;
                end else if (timeout_hit) begin
                    bus_err_d = 1'b1;
                    if (!w_en_q) load_data_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT: begin
                if (DMEM_Rsp_Valid) begin
                    load_data_d = load_aligned;
                    state_d     = DONE;
                end else if (timeout_hit) begin
                    bus_err_d   = 1'b1;
                    load_data_d = '0;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DONE: begin
                bus_err_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // Outputs decoded from state; IDLE reacts combinationally to the M stage.
    always_comb begin
        DMEM_Req_Valid = 1'b0;
        MEM_Stall      = 1'b0;
        MEM_Misaligned = 1'b0;
        case (state_q)
            IDLE: begin
                MEM_Misaligned = access & misaligned;
                MEM_Stall      = access & ~misaligned;
            end
            REQ: begin
                DMEM_Req_Valid = 1'b1;
                MEM_Stall      = 1'b1;
            end
            WAIT: MEM_Stall = 1'b1;
            DONE: ;
        endcase
    end

    assign DMEM_Req_Addr    = addr_q;
    assign DMEM_Req_W_En    = w_en_q;
    assign DMEM_Req_Byte_En = byte_en_q;
    assign DMEM_Req_W_Data  = w_data_q;
    assign MEM_Load_Data_M  = load_data_q;
    assign MEM_Bus_Err      = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit. Instance A uses the default timeout;
// instance B shares the same stimulus with TIMEOUT_CYCLES = 4 and is only
// inspected in the timeout scenario (it is resynchronised by reset first).
module tb_mem_access_unit;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        r_en = 1'b0, w_en = 1'b0;
    logic [2:0]  f3 = 3'b000;
    logic [31:0] addr = '0, sdata = '0;
    logic        ready = 1'b1, rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;

    logic        a_valid, a_we, a_stall, a_mis, a_err;
    logic [31:0] a_addr, a_wdata, a_load;
    logic [3:0]  a_be;
    logic        b_valid, b_we, b_stall, b_mis, b_err;
    logic [31:0] b_addr, b_wdata, b_load;
    logic [3:0]  b_be;

    int          compared = 0;
    int          mismatched = 0;
    int          hs_count = 0;
    int          ready_left = 0;
    bit          rsp_pending = 1'b0;
    bit          rsp_en = 1'b1;
    logic [31:0] rsp_word = '0;
    req_t        req_q[$];
    logic [31:0] load_q[$];

    always #5 CLK = ~CLK;

    mem_access_unit u_dut_a (
        .CLK(CLK), .RST(RST),
        .MEM_R_En_M(r_en), .MEM_W_En_M(w_en), .MEM_Control_M(f3),
        .ALU_Out_M(addr), .REG_R_Data2_M(sdata),
        .DMEM_Req_Valid(a_valid), .DMEM_Req_Ready(ready),
        .DMEM_Req_Addr(a_addr), .DMEM_Req_W_En(a_we),
        .DMEM_Req_Byte_En(a_be), .DMEM_Req_W_Data(a_wdata),
        .DMEM_Rsp_Valid(rsp_valid), .DMEM_Rsp_Data(rsp_data),
        .MEM_Stall(a_stall), .MEM_Load_Data_M(a_load),
        .MEM_Misaligned(a_mis), .MEM_Bus_Err(a_err)
    );

    mem_access_unit #(.TIMEOUT_CYCLES(4)) u_dut_b (
        .CLK(CLK), .RST(RST),
        .MEM_R_En_M(r_en), .MEM_W_En_M(w_en), .MEM_Control_M(f3),
        .ALU_Out_M(addr), .REG_R_Data2_M(sdata),
        .DMEM_Req_Valid(b_valid), .DMEM_Req_Ready(ready),
        .DMEM_Req_Addr(b_addr), .DMEM_Req_W_En(b_we),
        .DMEM_Req_Byte_En(b_be), .DMEM_Req_W_Data(b_wdata),
        .DMEM_Rsp_Valid(rsp_valid), .DMEM_Rsp_Data(rsp_data),
        .MEM_Stall(b_stall), .MEM_Load_Data_M(b_load),
        .MEM_Misaligned(b_mis), .MEM_Bus_Err(b_err)
    );

    // Memory model and request scoreboard for instance A, acting mid-cycle.
    always @(negedge CLK) begin
        req_t e;
        rsp_valid = 1'b0;
        if (rsp_pending && rsp_en) begin
            rsp_valid = 1'b1;
            rsp_data  = rsp_word;
        end
        rsp_pending = 1'b0;
        if (RST) begin
            ready = 1'b1;
        end else if (a_valid) begin
            if (ready_left > 0) begin
                ready = 1'b0;
                ready_left--;
            end else begin
                ready = 1'b1;
            end
            compared++;
            if (req_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_request: got addr %h with no request expected", a_addr);
            end else begin
                e = req_q[0];
                compared++;
                if (a_addr !== e.addr) begin
                    mismatched++;
                    $display("FAIL req_addr: got %h expected %h", a_addr, e.addr);
                end
                compared++;
                if (a_we !== e.we) begin
                    mismatched++;
                    $display("FAIL req_w_en: got %b expected %b", a_we, e.we);
                end
                compared++;
                if (a_be !== e.be) begin
                    mismatched++;
                    $display("FAIL req_byte_en: got %b expected %b", a_be, e.be);
                end
                if (e.we) begin
                    compared++;
                    if (a_wdata !== e.wdata) begin
                        mismatched++;
                        $display("FAIL req_w_data: got %h expected %h", a_wdata, e.wdata);
                    end
                end
                if (ready) begin
                    void'(req_q.pop_front());
                    hs_count++;
                    if (!e.we) rsp_pending = 1'b1;
                end
            end
        end else begin
            ready = 1'b1;
        end
    end

    task automatic set_idle();
        r_en = 1'b0; w_en = 1'b0; f3 = 3'b000; addr = '0; sdata = '0;
    endtask

    // Drive one access, queue its expected request/result, then check the
    // stall length, handshake count and load result once the DONE cycle shows.
    task automatic run_txn(input string name, input logic r, input logic w,
                           input logic [2:0] fn, input logic [31:0] ad,
                           input logic [31:0] d, input logic [31:0] rsp,
                           input int rdy_lo, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd, input logic [31:0] exp_ld,
                           input int exp_stalls);
        req_t        e;
        int          n;
        int          hs0;
        bit          done;
        logic [31:0] ld;
        @(posedge CLK); #1;
        r_en = r; w_en = w; f3 = fn; addr = ad; sdata = d;
        rsp_word = rsp; ready_left = rdy_lo;
        e.addr = {ad[31:2], 2'b00}; e.we = w; e.be = exp_be; e.wdata = exp_wd;
        req_q.push_back(e);
        if (r && !w) load_q.push_back(exp_ld);
        hs0 = hs_count; n = 0; done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge CLK);
            if (i == 0) begin
                compared++;
                if (a_mis !== 1'b0) begin
                    mismatched++;
                    $display("FAIL %s misaligned: got %b expected 0", name, a_mis);
                end
            end
            if (a_stall === 1'b1) n++;
            else done = 1'b1;
        end
        compared++;
        if (!done) begin
            mismatched++;
            $display("FAIL %s done_timeout: stall still high after %0d cycles", name, n);
        end
        compared++;
        if (n != exp_stalls) begin
            mismatched++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", name, n, exp_stalls);
        end
        compared++;
        if (hs_count - hs0 != 1) begin
            mismatched++;
            $display("FAIL %s handshakes: got %0d expected 1", name, hs_count - hs0);
        end
        compared++;
        if (a_err !== 1'b0) begin
            mismatched++;
            $display("FAIL %s bus_err: got %b expected 0", name, a_err);
        end
        if (r && !w && load_q.size() > 0) begin
            ld = load_q.pop_front();
            compared++;
            if (a_load !== ld) begin
                mismatched++;
                $display("FAIL %s load_data: got %h expected %h", name, a_load, ld);
            end
        end
    endtask

    task automatic test_reset();
        set_idle();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        compared++;
        if ({a_valid, a_we, a_be, a_stall, a_mis, a_err} !== 9'd0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got valid=%b we=%b be=%b stall=%b mis=%b err=%b expected all 0",
                     a_valid, a_we, a_be, a_stall, a_mis, a_err);
        end
        compared++;
        if ({a_addr, a_wdata, a_load} !== 96'd0) begin
            mismatched++;
            $display("FAIL reset_data: got addr=%h wdata=%h load=%h expected 0",
                     a_addr, a_wdata, a_load);
        end
    endtask

    task automatic test_store_lanes();
        run_txn("sw_100", 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, '0, 0,
                4'b1111, 32'hDEADBEEF, '0, 2);
        run_txn("sb_103", 1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, '0, 0,
                4'b1000, 32'hA5A5A5A5, '0, 2);
        run_txn("sh_102", 1'b0, 1'b1, 3'b001, 32'h102, 32'h00001234, '0, 0,
                4'b1100, 32'h12341234, '0, 2);
        run_txn("sb_100", 1'b0, 1'b1, 3'b000, 32'h100, 32'hFFFFFF3C, '0, 0,
                4'b0001, 32'h3C3C3C3C, '0, 2);
        run_txn("s_undef", 1'b0, 1'b1, 3'b011, 32'h108, 32'h00000055, '0, 0,
                4'b0000, 32'h00000055, '0, 2);
    endtask

    task automatic test_load_extend();
        run_txn("lb_201", 1'b1, 1'b0, 3'b000, 32'h201, '0, 32'h00008000, 0,
                4'b1111, '0, 32'hFFFFFF80, 3);
        run_txn("lbu_201", 1'b1, 1'b0, 3'b100, 32'h201, '0, 32'h00008000, 0,
                4'b1111, '0, 32'h00000080, 3);
        run_txn("lh_202", 1'b1, 1'b0, 3'b001, 32'h202, '0, 32'h80010000, 0,
                4'b1111, '0, 32'hFFFF8001, 3);
        run_txn("lhu_202", 1'b1, 1'b0, 3'b101, 32'h202, '0, 32'h80010000, 0,
                4'b1111, '0, 32'h00008001, 3);
        run_txn("lw_200", 1'b1, 1'b0, 3'b010, 32'h200, '0, 32'h13572468, 0,
                4'b1111, '0, 32'h13572468, 3);
    endtask

    task automatic test_backpressure();
        run_txn("sw_rdy_lo4", 1'b0, 1'b1, 3'b010, 32'h104, 32'hCAFEF00D, '0, 4,
                4'b1111, 32'hCAFEF00D, '0, 6);
        run_txn("lhu_rdy_lo2", 1'b1, 1'b0, 3'b101, 32'h206, '0, 32'hBEEF0000, 2,
                4'b1111, '0, 32'h0000BEEF, 5);
    endtask

    task automatic test_back_to_back();
        // Consecutive calls issue the next access on the cycle right after DONE.
        run_txn("b2b_sh", 1'b0, 1'b1, 3'b001, 32'h110, 32'h0000ABCD, '0, 0,
                4'b0011, 32'hABCDABCD, '0, 2);
        run_txn("b2b_rw", 1'b1, 1'b1, 3'b010, 32'h114, 32'h01020304, '0, 0,
                4'b1111, 32'h01020304, '0, 2);
        run_txn("b2b_lb", 1'b1, 1'b0, 3'b000, 32'h113, '0, 32'h7F000000, 0,
                4'b1111, '0, 32'h0000007F, 3);
    endtask

    task automatic test_misaligned();
        logic [2:0]  fns[2]  = '{3'b010, 3'b001};
        logic [31:0] adrs[2] = '{32'h102, 32'h101};
        int hs0;
        logic [31:0] ld0;
        for (int k = 0; k < 2; k++) begin
            @(posedge CLK); #1;
            hs0 = hs_count; ld0 = a_load;
            r_en = (k == 0); w_en = (k == 1); f3 = fns[k]; addr = adrs[k]; sdata = 32'h5A5A5A5A;
            for (int c = 0; c < 2; c++) begin
                @(negedge CLK);
                compared++;
                if ({a_mis, a_stall, a_valid} !== 3'b100) begin
                    mismatched++;
                    $display("FAIL misaligned_%0d: got mis=%b stall=%b valid=%b expected 1/0/0",
                             k, a_mis, a_stall, a_valid);
                end
            end
            compared++;
            if (hs_count != hs0 || a_load !== ld0) begin
                mismatched++;
                $display("FAIL misaligned_%0d_effect: got %0d handshakes load=%h expected 0 and %h",
                         k, hs_count - hs0, a_load, ld0);
            end
        end
        @(posedge CLK); #1 set_idle();
    endtask

    task automatic test_timeout_and_reset();
        req_t e;
        int   n;
        bit   done;
        // Resynchronise instance B with instance A.
        @(posedge CLK); #1 set_idle(); RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        run_txn("lw_300", 1'b1, 1'b0, 3'b010, 32'h300, '0, 32'h12345678, 0,
                4'b1111, '0, 32'h12345678, 3);
        compared++;
        if (b_load !== 32'h12345678) begin
            mismatched++;
            $display("FAIL b_load_ok: got %h expected 12345678", b_load);
        end
        // Load whose response never arrives.
        @(posedge CLK); #1;
        rsp_en = 1'b0; ready_left = 0;
        r_en = 1'b1; f3 = 3'b010; addr = 32'h304;
        e.addr = 32'h304; e.we = 1'b0; e.be = 4'b1111; e.wdata = '0;
        req_q.push_back(e);
        n = 0; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge CLK);
            if (b_stall === 1'b1) n++;
            else done = 1'b1;
        end
        compared++;
        if (!done || n != 6) begin
            mismatched++;
            $display("FAIL timeout_stalls: got %0d (done=%b) expected 6", n, done);
        end
        compared++;
        if ({b_err, b_valid} !== 2'b10 || b_load !== 32'd0) begin
            mismatched++;
            $display("FAIL timeout_done: got err=%b valid=%b load=%h expected 1/0/00000000",
                     b_err, b_valid, b_load);
        end
        compared++;
        if (a_stall !== 1'b1) begin
            mismatched++;
            $display("FAIL a_waiting: got stall=%b expected 1", a_stall);
        end
        @(posedge CLK); #1 set_idle();
        @(negedge CLK);
        compared++;
        if (b_err !== 1'b0) begin
            mismatched++;
            $display("FAIL timeout_err_clear: got %b expected 0", b_err);
        end
        // Instance A is still in WAIT: reset abandons the transaction.
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0; rsp_en = 1'b1;
        @(negedge CLK);
        compared++;
        if ({a_valid, a_stall, a_err} !== 3'b000 || a_addr !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_in_wait: got valid=%b stall=%b err=%b addr=%h expected 0",
                     a_valid, a_stall, a_err, a_addr);
        end
        run_txn("sw_after_rst", 1'b0, 1'b1, 3'b010, 32'h400, 32'h0BADF00D, '0, 0,
                4'b1111, 32'h0BADF00D, '0, 2);
    endtask

    initial begin
        test_reset();
        test_store_lanes();
        test_load_extend();
        test_backpressure();
        test_back_to_back();
        test_misaligned();
        test_timeout_and_reset();
        @(posedge CLK); #1 set_idle();
        repeat (2) @(negedge CLK);
        compared++;
        if (req_q.size() != 0 || load_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d requests and %0d loads left expected 0",
                     req_q.size(), load_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
